// File: rtl/regfile_dump_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_sequencer_pkg
//  Purpose  : Shared debug definitions for the register-file dump path:
//             sequencer state encoding, default frame-start marker and
//             UART byte width.
//  Revision : 1.0  initial release
// ============================================================================
package regfile_dump_sequencer_pkg;

    localparam int          c_uart_byte_w         = 8;
    localparam logic [7:0]  c_header_byte_default = 8'hA5;

    // Sequencer state encoding (3 bits)
    localparam logic [2:0]  c_st_idle   = 3'd0;
    localparam logic [2:0]  c_st_header = 3'd1;
    localparam logic [2:0]  c_st_addr   = 3'd2;
    localparam logic [2:0]  c_st_load   = 3'd3;
    localparam logic [2:0]  c_st_send   = 3'd4;
    localparam logic [2:0]  c_st_finish = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = c_st_idle,
        S_HEADER = c_st_header,
        S_ADDR   = c_st_addr,
        S_LOAD   = c_st_load,
        S_SEND   = c_st_send,
        S_FINISH = c_st_finish
    } dump_state_t;

endpackage : regfile_dump_sequencer_pkg
`default_nettype wire

// File: rtl/regfile_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_sequencer
//  Purpose  : Streams the register-file debug snapshot to the UART TX as one
//             frame: HEADER_BYTE, then registers 0..NUM_REGS-1, each sent
//             MSB byte first.
//  Ports    : clock, reset   - clock (posedge) and synchronous active-high reset
//             start          - 1-cycle dump request, honoured only when idle
//             reg_addr       - select for the external snapshot mux
//             reg_data       - mux output, valid one cycle after reg_addr moves
//             tx_data/valid  - byte stream to the UART, transfer on valid&&ready
//             tx_ready       - UART can accept a byte
//             busy           - high whenever a frame is in progress
//             done           - 1-cycle pulse after the final byte transfers
//  Revision : 1.0  initial release
// ============================================================================
module regfile_dump_sequencer
    import regfile_dump_sequencer_pkg::*;
#(
    parameter int         NUM_REGS    = 32,
    parameter int         DATA_WIDTH  = 32,
    parameter int         ADDR_WIDTH  = 5,
    parameter logic [7:0] HEADER_BYTE = c_header_byte_default
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int c_bytes_per_word = DATA_WIDTH / c_uart_byte_w;
    localparam int c_bcnt_w         = (c_bytes_per_word > 1) ? $clog2(c_bytes_per_word) : 1;

    localparam logic [c_bcnt_w-1:0]   c_last_byte = c_bcnt_w'(c_bytes_per_word - 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t           r_state,    w_state_next;
    logic [ADDR_WIDTH-1:0] r_reg_addr, w_reg_addr_next;
    logic [DATA_WIDTH-1:0] r_word,     w_word_next;
    logic [DATA_WIDTH-1:0] w_word_shift;
    logic [7:0]            r_tx_data,  w_tx_data_next;
    logic                  r_tx_valid, w_tx_valid_next;
    logic                  r_done,     w_done_next;
    logic [c_bcnt_w-1:0]   r_byte_cnt, w_byte_cnt_next;
    logic                  w_handshake;

    assign w_handshake  = r_tx_valid && tx_ready;
    // The word is consumed from the top; the next byte to present is the
    // top byte of the already-shifted word.
    assign w_word_shift = r_word << c_uart_byte_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_reg_addr <= '0;
            r_word     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_reg_addr <= w_reg_addr_next;
            r_word     <= w_word_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_done     <= w_done_next;
            r_byte_cnt <= w_byte_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_reg_addr_next = r_reg_addr;
        w_word_next     = r_word;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = r_tx_valid;
        w_done_next     = 1'b0;
        w_byte_cnt_next = r_byte_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next    = S_HEADER;
                    w_tx_data_next  = HEADER_BYTE;
                    w_tx_valid_next = 1'b1;
                    w_reg_addr_next = '0;
                end
            end
            S_HEADER: begin
                if (w_handshake) begin
                    w_state_next    = S_ADDR;
                    w_tx_valid_next = 1'b0;
                end
            end
            // Gives the registered snapshot mux one cycle to follow reg_addr.
            S_ADDR: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_word_next     = reg_data;
                w_tx_data_next  = reg_data[DATA_WIDTH-1 -: 8];
                w_tx_valid_next = 1'b1;
                w_byte_cnt_next = '0;
                w_state_next    = S_SEND;
            end
            S_SEND: begin
                if (w_handshake) begin
                    if (r_byte_cnt < c_last_byte) begin
                        // Keep tx_valid high: bytes of one word go back to back.
                        w_word_next     = w_word_shift;
                        w_tx_data_next  = w_word_shift[DATA_WIDTH-1 -: 8];
                        w_byte_cnt_next = r_byte_cnt + c_bcnt_w'(1);
                    end else if (r_reg_addr == c_last_addr) begin
                        w_tx_valid_next = 1'b0;
                        w_done_next     = 1'b1;
                        w_state_next    = S_FINISH;
                    end else begin
                        w_reg_addr_next = r_reg_addr + ADDR_WIDTH'(1);
                        w_tx_valid_next = 1'b0;
                        w_state_next    = S_ADDR;
                    end
                end
            end
            // done is registered on entry, so it is high exactly during this
            // state; a start arriving here is ignored.
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next    = S_IDLE;
                w_tx_valid_next = 1'b0;
            end
        endcase
    end

    assign reg_addr = r_reg_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);

endmodule : regfile_dump_sequencer
`default_nettype wire

// File: tb/tb_regfile_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump_sequencer
//  Purpose  : Self-checking bench for regfile_dump_sequencer. Instance A uses
//             the default 32 x 32-bit geometry, instance B uses 4 x 16-bit.
//             Expected bytes are queued when a frame is started and popped as
//             handshakes occur.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_dump_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        start_a, tx_valid_a, tx_ready_a, busy_a, done_a;
    logic [4:0]  reg_addr_a;
    logic [31:0] reg_data_a;
    logic [7:0]  tx_data_a;

    logic        start_b, tx_valid_b, tx_ready_b, busy_b, done_b;
    logic [2:0]  reg_addr_b;
    logic [15:0] reg_data_b;
    logic [7:0]  tx_data_b;

    logic [31:0] regs_a [32];
    logic [15:0] regs_b [4];

    // Registered snapshot muxes
    always @(posedge clock) reg_data_a <= regs_a[reg_addr_a];
    always @(posedge clock) reg_data_b <= (reg_addr_b < 3'd4) ? regs_b[reg_addr_b[1:0]] : 16'h0;

    regfile_dump_sequencer dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .reg_addr(reg_addr_a), .reg_data(reg_data_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .busy(busy_a), .done(done_a)
    );

    regfile_dump_sequencer #(
        .NUM_REGS(4), .DATA_WIDTH(16), .ADDR_WIDTH(3), .HEADER_BYTE(8'hA5)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .reg_addr(reg_addr_b), .reg_data(reg_data_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];

    int bytes_a, bytes_b, done_cnt_a, done_cnt_b, last_hs_a, last_hs_b;
    logic stall_a, stall_b, pdone_a, pdone_b;
    logic [7:0] held_a, held_b;
    int mode_a, mode_b;   // tx_ready pattern: 0 hold, 1 toggle, 2 random

    typedef struct packed {
        logic [63:0] regs;   // r0..r3, r0 in the top 16 bits
        logic [1:0]  mode;
        logic [71:0] exp;    // expected frame, first byte in the top 8 bits
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input string tag, input logic v, input logic rdy, input logic [7:0] d,
                       input logic dn, inout logic stall, inout logic [7:0] held,
                       inout logic pdone, inout int bytes, inout int last_hs,
                       inout int dcnt, output logic hs);
        if (stall)
            check({tag, "_stall_hold"}, 64'({v, d}), 64'({1'b1, held}));
        hs = v && rdy;
        if (hs) begin
            bytes++;
            last_hs = cyc;
        end
        if (dn) begin
            check({tag, "_done_after_last_byte"}, 64'(cyc - last_hs), 64'd1);
            check({tag, "_done_width"}, 64'(pdone), 64'd0);
            dcnt++;
        end
        stall = v && !rdy && !reset;
        held  = d;
        pdone = dn;
    endtask

    // One clock: monitor at the falling edge, drive just after the rising edge.
    task automatic tick();
        logic hs;
        @(negedge clock);
        cyc++;
        mon("a", tx_valid_a, tx_ready_a, tx_data_a, done_a, stall_a, held_a, pdone_a,
            bytes_a, last_hs_a, done_cnt_a, hs);
        if (hs) begin
            check("a_byte_expected", 64'(q_a.size() > 0), 64'd1);
            if (q_a.size() > 0) check("a_byte", 64'(tx_data_a), 64'(q_a.pop_front()));
        end
        mon("b", tx_valid_b, tx_ready_b, tx_data_b, done_b, stall_b, held_b, pdone_b,
            bytes_b, last_hs_b, done_cnt_b, hs);
        if (hs) begin
            check("b_byte_expected", 64'(q_b.size() > 0), 64'd1);
            if (q_b.size() > 0) check("b_byte", 64'(tx_data_b), 64'(q_b.pop_front()));
        end
        check("b_reg_addr_range", 64'(reg_addr_b < 3'd4), 64'd1);
        @(posedge clock);
        #1;
        case (mode_a)
            1: tx_ready_a = ~tx_ready_a;
            2: tx_ready_a = 1'($urandom_range(0, 1));
            default: ;
        endcase
        case (mode_b)
            1: tx_ready_b = ~tx_ready_b;
            2: tx_ready_b = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic push_frame_a();
        q_a.push_back(8'hA5);
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--)
                q_a.push_back(regs_a[r][8*b +: 8]);
        bytes_a = 0;
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int d0;
        d0 = (which == 0) ? done_cnt_a : done_cnt_b;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (((which == 0) ? done_cnt_a : done_cnt_b) != d0) break;
        end
        check((which == 0) ? "a_done_seen" : "b_done_seen",
              64'(((which == 0) ? done_cnt_a : done_cnt_b) - d0), 64'd1);
    endtask

    vec_t tbl [3];

    initial begin
        int d0;
        vec_t v;

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        tx_ready_a = 1'b1; tx_ready_b = 1'b1;
        mode_a = 0; mode_b = 0;
        bytes_a = 0; bytes_b = 0; done_cnt_a = 0; done_cnt_b = 0;
        last_hs_a = 0; last_hs_b = 0;
        stall_a = 1'b0; stall_b = 1'b0; pdone_a = 1'b0; pdone_b = 1'b0;
        held_a = 8'h0; held_b = 8'h0;
        for (int i = 0; i < 32; i++) regs_a[i] = 32'h0;
        for (int i = 0; i < 4; i++) regs_b[i] = 16'h0;

        tbl[0] = '{64'h1111_2222_3333_4444, 2'd0, 72'hA5_1111_2222_3333_4444};
        tbl[1] = '{64'h0000_FFFF_00FF_FF00, 2'd1, 72'hA5_0000_FFFF_00FF_FF00};
        tbl[2] = '{64'hABCD_1234_8001_7FFE, 2'd2, 72'hA5_ABCD_1234_8001_7FFE};

        // Reset state
        repeat (3) tick();
        check("rst_reg_addr", 64'(reg_addr_a), 64'd0);
        check("rst_tx_data",  64'(tx_data_a),  64'd0);
        check("rst_tx_valid", 64'(tx_valid_a), 64'd0);
        check("rst_busy",     64'(busy_a),     64'd0);
        check("rst_done",     64'(done_a),     64'd0);
        check("rst_b_valid_busy", 64'({tx_valid_b, busy_b}), 64'd0);
        reset = 1'b0;
        tick();

        // Full frame with ready held high
        regs_a[0] = 32'd2;
        regs_a[1] = 32'd3;
        push_frame_a();
        pulse_start(0);
        check("a_busy_after_start", 64'(busy_a), 64'd1);
        wait_done(0, 2000);
        check("t1_byte_count", 64'(bytes_a), 64'd129);
        check("t1_queue_empty", 64'(q_a.size()), 64'd0);
        check("t1_busy_low", 64'(busy_a), 64'd0);

        // Ready toggling every cycle
        regs_a[5] = 32'hDEADBEEF;
        mode_a = 1;
        push_frame_a();
        pulse_start(0);
        wait_done(0, 2000);
        mode_a = 0;
        tx_ready_a = 1'b1;
        check("t2_byte_count", 64'(bytes_a), 64'd129);
        check("t2_queue_empty", 64'(q_a.size()), 64'd0);

        // Second start mid-frame is ignored
        push_frame_a();
        d0 = done_cnt_a;
        pulse_start(0);
        for (int i = 0; i < 1000 && bytes_a < 40; i++) tick();
        check("t3_busy_at_byte40", 64'(busy_a), 64'd1);
        pulse_start(0);
        wait_done(0, 2000);
        repeat (20) tick();
        check("t3_byte_count", 64'(bytes_a), 64'd129);
        check("t3_one_done", 64'(done_cnt_a - d0), 64'd1);
        check("t3_idle_after", 64'({busy_a, tx_valid_a}), 64'd0);
        check("t3_queue_empty", 64'(q_a.size()), 64'd0);

        // Reset while stalled in SEND
        push_frame_a();
        pulse_start(0);
        for (int i = 0; i < 1000 && bytes_a < 3; i++) tick();
        tx_ready_a = 1'b0;
        repeat (4) tick();
        check("t4_stalled_valid", 64'(tx_valid_a), 64'd1);
        d0 = done_cnt_a;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_valid_dropped", 64'(tx_valid_a), 64'd0);
        check("t4_busy_dropped",  64'(busy_a),     64'd0);
        check("t4_no_done",       64'(done_a),     64'd0);
        q_a.delete();
        repeat (5) tick();
        check("t4_no_done_later", 64'(done_cnt_a - d0), 64'd0);
        tx_ready_a = 1'b1;
        push_frame_a();
        pulse_start(0);
        wait_done(0, 2000);
        check("t4_fresh_byte_count", 64'(bytes_a), 64'd129);
        check("t4_queue_empty", 64'(q_a.size()), 64'd0);

        // Small geometry, table-driven frames
        for (int i = 0; i < 3; i++) begin
            v = tbl[i];
            for (int j = 0; j < 4; j++) regs_b[j] = v.regs[63-16*j -: 16];
            mode_b = int'(v.mode);
            for (int k = 0; k < 9; k++) q_b.push_back(v.exp[71-8*k -: 8]);
            bytes_b = 0;
            pulse_start(1);
            wait_done(1, 500);
            mode_b = 0;
            tx_ready_b = 1'b1;
            check("t5_byte_count", 64'(bytes_b), 64'd9);
            check("t5_queue_empty", 64'(q_b.size()), 64'd0);
            check("t5_busy_low", 64'(busy_b), 64'd0);
        end

        // start during FINISH is dropped; start on the first IDLE cycle is taken
        v = tbl[0];
        for (int j = 0; j < 4; j++) regs_b[j] = v.regs[63-16*j -: 16];
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 9; k++) q_b.push_back(v.exp[71-8*k -: 8]);
        bytes_b = 0;
        pulse_start(1);
        for (int i = 0; i < 500 && bytes_b < 9; i++) tick();
        pulse_start(1);
        check("b_start_in_finish_dropped", 64'(busy_b), 64'd0);
        pulse_start(1);
        check("b_first_idle_start", 64'({busy_b, tx_valid_b, tx_data_b}), 64'h3A5);
        wait_done(1, 500);
        check("b_second_frame_bytes", 64'(bytes_b), 64'd18);
        check("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_regfile_dump_sequencer
`default_nettype wire
